// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset pulse, lock wait with retry, lock-loss re-sequencing and hard-fail flag
module pll_rst_seq #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pll_locked,
    output logic       pll_areset,
    output logic       user_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);
    localparam logic [2:0] S_ASSERT = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_FAIL   = 3'd3;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cyc_cnt, cyc_nxt, stable_cnt, stable_nxt;
    logic [3:0]       retry_nxt;
    logic [7:0]       loss_nxt;
    logic             locked_meta, locked_sync;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_sync <= locked_meta;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= S_ASSERT;
            cyc_cnt       <= '0;
            stable_cnt    <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= state_nxt;
            cyc_cnt       <= cyc_nxt;
            stable_cnt    <= stable_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cyc_nxt    = cyc_cnt;
        stable_nxt = stable_cnt;
        retry_nxt  = retry_cnt;
        loss_nxt   = lock_loss_cnt;
        case (state)
            S_ASSERT: begin
                cyc_nxt = cyc_cnt + 1'b1;
                if (cyc_cnt == CNT_W'(RST_PULSE_CYC - 1)) begin
                    state_nxt  = S_WAIT;
                    cyc_nxt    = '0;
                    stable_nxt = '0;
                end
            end
            S_WAIT: begin
                cyc_nxt    = cyc_cnt + 1'b1;
                stable_nxt = locked_sync ? stable_cnt + 1'b1 : '0;
                // a lock completing on the timeout cycle still counts as a lock
                if (locked_sync && stable_cnt == CNT_W'(LOCK_STABLE_CYC - 1)) begin
                    state_nxt = S_RUN;
                    retry_nxt = '0;
                end else if (cyc_cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    retry_nxt = retry_cnt + 4'd1;
                    state_nxt = (retry_cnt + 4'd1 == 4'(MAX_RETRY)) ? S_FAIL : S_ASSERT;
                    cyc_nxt   = '0;
                end
            end
            S_RUN: begin
                if (!locked_sync) begin
                    state_nxt = S_ASSERT;
                    cyc_nxt   = '0;
                    loss_nxt  = (&lock_loss_cnt) ? lock_loss_cnt : lock_loss_cnt + 8'd1;
                end
            end
            S_FAIL: state_nxt = S_FAIL;
            default: begin
                state_nxt  = S_ASSERT;
                cyc_nxt    = '0;
                stable_nxt = '0;
            end
        endcase
    end

    always_comb begin
        pll_areset = (state == S_ASSERT) || (state == S_FAIL);
        user_rst   = state != S_RUN;
        ready      = state == S_RUN;
        fail       = state == S_FAIL;
    end
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed stimulus pushes expected output-change events; a monitor pops and checks them
module tb_pll_rst_seq;
    logic       sys_clk = 1'b0;
    logic       sys_rst, pll_locked;
    logic       pll_areset, user_rst, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    typedef struct packed {
        int          e;
        logic [15:0] v;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_ev;
    logic [15:0] mon_cur;
    logic [15:0] prev = 'x;
    int          edge_n = 0;
    int          total = 0;
    int          bad = 0;
    int          exp_retry = 0;
    int          exp_loss = 0;
    int          f_edge = 0;

    pll_rst_seq #(
        .RST_PULSE_CYC(4),
        .LOCK_TIMEOUT_CYC(40),
        .LOCK_STABLE_CYC(8),
        .MAX_RETRY(2),
        .CNT_W(16)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .pll_locked(pll_locked),
        .pll_areset(pll_areset),
        .user_rst(user_rst),
        .ready(ready),
        .fail(fail),
        .retry_cnt(retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) edge_n <= edge_n + 1;

    // every output change must match the next expected event, on the expected edge
    always @(negedge sys_clk) begin
        mon_cur = {pll_areset, user_rst, ready, fail, retry_cnt, lock_loss_cnt};
        if (mon_cur !== prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change edge=%0d got=%h", edge_n, mon_cur);
            end else begin
                mon_ev = exp_q.pop_front();
                if (mon_ev.e != edge_n || mon_ev.v !== mon_cur) begin
                    bad++;
                    $display("FAIL event got edge=%0d val=%h expected edge=%0d val=%h",
                             edge_n, mon_cur, mon_ev.e, mon_ev.v);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].e <= edge_n) begin
            total++;
            bad++;
            mon_ev = exp_q.pop_front();
            $display("FAIL missed_change at edge=%0d got=%h expected edge=%0d val=%h",
                     edge_n, mon_cur, mon_ev.e, mon_ev.v);
        end
        prev = mon_cur;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic push(input int e, input logic a, input logic u, input logic r, input logic f);
        ev_t t;
        t.e = e;
        t.v = {a, u, r, f, 4'(exp_retry), 8'(exp_loss)};
        exp_q.push_back(t);
    endtask

    task automatic do_reset();
        sys_rst    = 1'b1;
        pll_locked = 1'b0;
        exp_retry  = 0;
        exp_loss   = 0;
        push(edge_n + 1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        sys_rst = 1'b0;
        f_edge  = edge_n + 4;
        push(f_edge, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic raise_lock_at(input int e);
        wait_to(e - 1);
        pll_locked = 1'b1;
    endtask

    initial begin
        int e1, e2, d;
        // normal lock, 10 cycles after pll_areset falls
        do_reset();
        e1 = f_edge + 10;
        raise_lock_at(e1);
        push(e1 + 9, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_to(e1 + 12);
        // glitchy lock: 5 high, 1 low, then steady
        do_reset();
        e1 = f_edge + 5;
        raise_lock_at(e1);
        wait_to(e1 + 4);
        pll_locked = 1'b0;
        wait_to(e1 + 5);
        pll_locked = 1'b1;
        e2 = e1 + 6;
        push(e2 + 9, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_to(e2 + 12);
        // lock loss, repeated past saturation of lock_loss_cnt
        for (int i = 0; i < 300; i++) begin
            d = edge_n + 1;
            pll_locked = 1'b0;
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            push(d + 2, 1'b1, 1'b1, 1'b0, 1'b0);
            push(d + 6, 1'b0, 1'b1, 1'b0, 1'b0);
            push(d + 14, 1'b0, 1'b0, 1'b1, 1'b0);
            wait_to(d + 2);
            pll_locked = 1'b1;
            wait_to(d + 16);
        end
        // reset in RUN, then reset in WAIT_LOCK
        do_reset();
        wait_to(f_edge + 5);
        do_reset();
        // stable completes exactly on the timeout cycle
        raise_lock_at(f_edge + 31);
        push(f_edge + 40, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_to(f_edge + 43);
        // one cycle later: timeout wins, retry, then lock on the next attempt
        do_reset();
        raise_lock_at(f_edge + 32);
        exp_retry = 1;
        push(f_edge + 40, 1'b1, 1'b1, 1'b0, 1'b0);
        push(f_edge + 44, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_retry = 0;
        push(f_edge + 52, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_to(f_edge + 55);
        // never lock: two attempts then terminal FAIL held for 200 cycles
        do_reset();
        exp_retry = 1;
        push(f_edge + 40, 1'b1, 1'b1, 1'b0, 1'b0);
        push(f_edge + 44, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_retry = 2;
        push(f_edge + 84, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_to(f_edge + 284);
        // reset out of FAIL
        do_reset();
        wait_to(f_edge + 3);
        wait_to(edge_n + 5);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
